// File: rtl/setup_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : setup_ctrl
//  Description : Arbitration between the operational and setup blocks of the
//                lock. A master-password submission (digit 0xB as the newest
//                nibble) that matches the stored master opens a setup session.
//                Keypad strobes, display data and the active configuration are
//                routed according to the session state. Setup sessions end by
//                commit (new cfg latched) or by inactivity timeout (abort).
//
//  Optional feature macro : SETUP_CTRL_LOCKOUT_EN
//      defined   -> wrong master submissions are counted; MAX_FAIL in a row
//                   lock the controller for LOCK_CYCLES cycles.
//      undefined -> wrong master submissions are consumed and ignored.
//
//  Ports
//      clk, rst               : clock, synchronous active-high reset
//      digitos_value[79:0]    : keypad buffer, nibble 0 ([3:0]) is newest
//      digitos_valid          : keypad strobe
//      bcd_op/bcd_setup[31:0] : display data from operational / setup block
//      setup_display_en       : display enable from setup block
//      data_setup_new[416:0]  : new configuration from setup block
//      data_setup_ok          : commit strobe from setup block
//      setup_on               : setup-entry request (2 cycles)
//      setup_abort            : one-cycle reset pulse to the setup block
//      setup_digitos_valid    : keypad strobe routed to setup block
//      op_digitos_valid       : keypad strobe routed to operational block
//      bcd_out[31:0], display_en : muxed display
//      cfg[416:0]             : active configuration
//      in_setup, lockout      : status
//
//  Configuration word layout (cfg / data_setup_new)
//      [416]     bip_status
//      [415:408] bip_time
//      [407:400] tranca_aut_time
//      [399:320] senha_4   [319:240] senha_3
//      [239:160] senha_2   [159:80]  senha_1
//      [79:0]    senha_master (20 nibbles, [3:0] is digits[0])
//
//  Revision    : 1.0 - initial release
// ============================================================================
module setup_ctrl #(
    parameter int TIMEOUT_CYCLES = 10000,
    parameter int MAX_FAIL       = 3,
    parameter int LOCK_CYCLES    = 30000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [79:0]  digitos_value,
    input  logic         digitos_valid,
    input  logic [31:0]  bcd_op,
    input  logic [31:0]  bcd_setup,
    input  logic         setup_display_en,
    input  logic [416:0] data_setup_new,
    input  logic         data_setup_ok,
    output logic         setup_on,
    output logic         setup_abort,
    output logic         setup_digitos_valid,
    output logic         op_digitos_valid,
    output logic [31:0]  bcd_out,
    output logic         display_en,
    output logic [416:0] cfg,
    output logic         in_setup,
    output logic         lockout
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [2:0] c_OPER    = 3'd0;
    localparam logic [2:0] c_ARM     = 3'd1;
    localparam logic [2:0] c_SETUP   = 3'd2;
    localparam logic [2:0] c_COMMIT  = 3'd3;
    localparam logic [2:0] c_LOCKOUT = 3'd4;

    localparam logic [416:0] c_CFG_RESET = {1'b1, 8'd5, 8'd5, {320{1'b1}},
                                            {64{1'b1}}, 16'h1234};

    // One shared timer serves ARM, SETUP inactivity and LOCKOUT.
`ifdef SETUP_CTRL_LOCKOUT_EN
    localparam int c_tmr_max = (TIMEOUT_CYCLES > LOCK_CYCLES) ? TIMEOUT_CYCLES : LOCK_CYCLES;
`else
    localparam int c_tmr_max = TIMEOUT_CYCLES;
`endif
    localparam int c_tmr_w = (c_tmr_max < 2) ? 1 : $clog2(c_tmr_max);

    localparam logic [c_tmr_w-1:0] c_timeout_last = c_tmr_w'(TIMEOUT_CYCLES - 1);
    localparam logic [c_tmr_w-1:0] c_arm_last     = c_tmr_w'(1);

    logic [2:0]         r_state;
    logic [2:0]         w_next_state;
    logic [c_tmr_w-1:0] r_timer;
    logic [416:0]       r_cfg;
    logic [416:0]       r_pending;

    logic w_submit;
    logic w_match;
    logic w_timeout;
    logic w_fail_limit;

    assign w_submit  = digitos_valid && (digitos_value[3:0] == 4'hB);
    // The '#' nibble is dropped and the buffer is aligned to the stored master.
    assign w_match   = ({4'hF, digitos_value[79:4]} == r_cfg[79:0]);
    // A keypress in the expiry cycle still counts as activity.
    assign w_timeout = (r_timer == c_timeout_last) && !digitos_valid;

`ifdef SETUP_CTRL_LOCKOUT_EN
    localparam int c_fail_w = (MAX_FAIL < 1) ? 1 : $clog2(MAX_FAIL + 1);
    localparam logic [c_fail_w-1:0]  c_fail_max  = c_fail_w'(MAX_FAIL);
    localparam logic [c_fail_w-1:0]  c_fail_last = c_fail_w'(MAX_FAIL - 1);
    localparam logic [c_tmr_w-1:0]   c_lock_last = c_tmr_w'(LOCK_CYCLES - 1);

    logic [c_fail_w-1:0] r_fail_cnt;

    assign w_fail_limit = (r_fail_cnt == c_fail_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fail_cnt <= '0;
        end else if (r_state == c_OPER && w_submit) begin
            if (w_match) begin
                r_fail_cnt <= '0;
            end else if (r_fail_cnt != c_fail_max) begin
                r_fail_cnt <= r_fail_cnt + c_fail_w'(1);
            end
        end else if (r_state == c_LOCKOUT && w_next_state == c_OPER) begin
            r_fail_cnt <= '0;
        end
    end
`else
    // Lockout parameters have no effect in this build.
    logic w_unused_params;
    assign w_unused_params = (MAX_FAIL == 0) || (LOCK_CYCLES == 0);
    assign w_fail_limit    = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State register, timer and configuration storage
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_OPER;
            r_timer   <= '0;
            r_cfg     <= c_CFG_RESET;
            r_pending <= c_CFG_RESET;
        end else begin
            r_state <= w_next_state;

            if (w_next_state != r_state) begin
                r_timer <= '0;
            end else if (r_state == c_ARM || r_state == c_LOCKOUT ||
                         (r_state == c_SETUP && !digitos_valid)) begin
                r_timer <= r_timer + c_tmr_w'(1);
            end else begin
                r_timer <= '0;
            end

            // Capture at the commit strobe so the setup block need not hold it.
            if (r_state == c_SETUP && data_setup_ok) begin
                r_pending <= data_setup_new;
            end
            if (r_state == c_COMMIT) begin
                r_cfg <= r_pending;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_OPER: begin
                if (w_submit) begin
                    if (w_match) begin
                        w_next_state = c_ARM;
                    end else if (w_fail_limit) begin
                        w_next_state = c_LOCKOUT;
                    end
                end
            end
            c_ARM: begin
                if (r_timer == c_arm_last) begin
                    w_next_state = c_SETUP;
                end
            end
            c_SETUP: begin
                // Commit has priority over a simultaneous timeout.
                if (data_setup_ok) begin
                    w_next_state = c_COMMIT;
                end else if (w_timeout) begin
                    w_next_state = c_OPER;
                end
            end
            c_COMMIT: begin
                w_next_state = c_OPER;
            end
            c_LOCKOUT: begin
`ifdef SETUP_CTRL_LOCKOUT_EN
                if (r_timer == c_lock_last) begin
                    w_next_state = c_OPER;
                end
`else
                w_next_state = c_OPER;
`endif
            end
            default: begin
                w_next_state = c_OPER;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        setup_on            = 1'b0;
        setup_abort         = 1'b0;
        setup_digitos_valid = 1'b0;
        op_digitos_valid    = 1'b0;
        in_setup            = 1'b0;
        lockout             = 1'b0;
        bcd_out             = bcd_op;
        display_en          = 1'b1;
        case (r_state)
            c_OPER: begin
                op_digitos_valid = digitos_valid && !w_submit;
            end
            c_ARM: begin
                setup_on   = 1'b1;
                in_setup   = 1'b1;
                bcd_out    = bcd_setup;
                display_en = setup_display_en;
            end
            c_SETUP: begin
                in_setup            = 1'b1;
                setup_digitos_valid = digitos_valid;
                setup_abort         = w_timeout && !data_setup_ok;
                bcd_out             = bcd_setup;
                display_en          = setup_display_en;
            end
            c_LOCKOUT: begin
`ifdef SETUP_CTRL_LOCKOUT_EN
                lockout = 1'b1;
`endif
            end
            default: begin
            end
        endcase
    end

    assign cfg = r_cfg;

endmodule
`default_nettype wire

// File: tb/tb_setup_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_setup_ctrl
//  Description : Self-checking bench for setup_ctrl. A behavioural session
//                model predicts every output each cycle; directed scenarios
//                are followed by a randomized traffic phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_setup_ctrl;

    localparam int TIMEOUT = 50;
    localparam int MAXF    = 3;
    localparam int LOCKC   = 100;
`ifdef SETUP_CTRL_LOCKOUT_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    localparam logic [416:0] CFG_DEF = {1'b1, 8'd5, 8'd5, {320{1'b1}},
                                        {64{1'b1}}, 16'h1234};
    localparam logic [79:0] GOOD_PW  = {{60{1'b1}}, 20'h1234B};
    localparam logic [79:0] BAD_PW   = {{60{1'b1}}, 20'h9999B};

    // session phases of the reference model
    localparam int P_IDLE = 0, P_ARMING = 1, P_CONF = 2, P_SAVE = 3, P_BLOCKED = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [79:0]  dv_val;
    logic         dv;
    logic [31:0]  bcd_op, bcd_setup;
    logic         sde;
    logic [416:0] dsn;
    logic         dok;

    logic         setup_on, setup_abort, setup_dv, op_dv, display_en, in_setup, lockout;
    logic [31:0]  bcd_out;
    logic [416:0] cfg;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    int           m_phase;
    int           m_arm_left;
    int           m_idle;
    int           m_lock_left;
    int           m_fails;
    logic [416:0] m_cfg;
    logic [416:0] m_pend;

    setup_ctrl #(
        .TIMEOUT_CYCLES(TIMEOUT),
        .MAX_FAIL      (MAXF),
        .LOCK_CYCLES   (LOCKC)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .digitos_value      (dv_val),
        .digitos_valid      (dv),
        .bcd_op             (bcd_op),
        .bcd_setup          (bcd_setup),
        .setup_display_en   (sde),
        .data_setup_new     (dsn),
        .data_setup_ok      (dok),
        .setup_on           (setup_on),
        .setup_abort        (setup_abort),
        .setup_digitos_valid(setup_dv),
        .op_digitos_valid   (op_dv),
        .bcd_out            (bcd_out),
        .display_en         (display_en),
        .cfg                (cfg),
        .in_setup           (in_setup),
        .lockout            (lockout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [416:0] rand_cfg();
        logic [447:0] t;
        for (int i = 0; i < 14; i++) t[i*32 +: 32] = $urandom;
        t[79:76] = 4'hF;   // keeps the new master reachable from the keypad
        return t[416:0];
    endfunction

    function automatic logic [79:0] rand_keys(input logic [3:0] newest);
        logic [95:0] t;
        for (int i = 0; i < 3; i++) t[i*32 +: 32] = $urandom;
        t[3:0] = newest;
        return t[79:0];
    endfunction

    task automatic model_reset();
        m_phase = P_IDLE; m_arm_left = 0; m_idle = 0; m_lock_left = 0;
        m_fails = 0; m_cfg = CFG_DEF; m_pend = CFG_DEF;
    endtask

    // Predicted outputs for the current cycle, compared before the edge;
    // the model then advances with the same inputs the DUT sampled.
    task automatic tick(input bit chk_en);
        bit e_in, e_abort;
        @(negedge clk);
        if (chk_en) begin
            e_in    = (m_phase == P_ARMING) || (m_phase == P_CONF);
            e_abort = (m_phase == P_CONF) && !dv && !dok && (m_idle + 1 == TIMEOUT);
            check("setup_on",    setup_on,    m_phase == P_ARMING);
            check("setup_abort", setup_abort, e_abort);
            check("setup_dv",    setup_dv,    (m_phase == P_CONF) && dv);
            check("op_dv",       op_dv,       (m_phase == P_IDLE) && dv && dv_val[3:0] != 4'hB);
            check("bcd_out",     bcd_out,     e_in ? bcd_setup : bcd_op);
            check("display_en",  display_en,  e_in ? sde : 1'b1);
            check("cfg",         cfg,         m_cfg);
            check("in_setup",    in_setup,    e_in);
            check("lockout",     lockout,     m_phase == P_BLOCKED);
        end
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            case (m_phase)
                P_IDLE: if (dv && dv_val[3:0] == 4'hB) begin
                    if (((dv_val >> 4) | (80'hF << 76)) == m_cfg[79:0]) begin
                        m_phase = P_ARMING; m_arm_left = 2; m_fails = 0;
                    end else if (LOCK_EN) begin
                        m_fails = (m_fails + 1 > MAXF) ? MAXF : m_fails + 1;
                        if (m_fails >= MAXF) begin
                            m_phase = P_BLOCKED; m_lock_left = LOCKC;
                        end
                    end
                end
                P_ARMING: begin
                    m_arm_left--;
                    if (m_arm_left == 0) begin m_phase = P_CONF; m_idle = 0; end
                end
                P_CONF: begin
                    if (dok) begin m_phase = P_SAVE; m_pend = dsn; end
                    else if (!dv && m_idle + 1 == TIMEOUT) m_phase = P_IDLE;
                    else m_idle = dv ? 0 : m_idle + 1;
                end
                P_SAVE: begin m_cfg = m_pend; m_phase = P_IDLE; end
                default: begin
                    m_lock_left--;
                    if (m_lock_left == 0) begin m_phase = P_IDLE; m_fails = 0; end
                end
            endcase
        end
        #1;
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) begin
            dv = 1'b0; dok = 1'b0;
            bcd_op = $urandom; bcd_setup = $urandom; sde = 1'($urandom);
            tick(1'b1);
        end
    endtask

    task automatic key(input logic [79:0] v);
        dv = 1'b1; dv_val = v; dok = 1'b0;
        tick(1'b1);
        dv = 1'b0;
    endtask

    initial begin
        rst = 1'b1; dv = 1'b0; dok = 1'b0; dv_val = '1;
        bcd_op = 32'h1111_1111; bcd_setup = 32'h2222_2222; sde = 1'b0;
        dsn = CFG_DEF;
        model_reset();
        tick(1'b0);
        tick(1'b1);
        rst = 1'b0;
        check("rst_cfg", cfg, CFG_DEF);
        check("rst_in_setup", in_setup, 1'b0);

        // ordinary digit goes to the operational block
        key({{76{1'b1}}, 4'h5});
        quiet(2);

        // correct master -> ARM (2 cycles) -> SETUP, then commit bip_time=23
        key(GOOD_PW);
        quiet(3);
        check("arm_in_setup", in_setup, 1'b1);
        key({{76{1'b1}}, 4'h7});
        dsn = CFG_DEF; dsn[415:408] = 8'd23;
        dok = 1'b1; tick(1'b1); dok = 1'b0;
        quiet(2);
        check("commit_bip_time", cfg[415:408], 8'd23);
        check("commit_in_setup", in_setup, 1'b0);

        // inactivity timeout
        key(GOOD_PW);
        quiet(TIMEOUT + 10);
        check("abort_cfg_kept", cfg[415:408], 8'd23);

        // wrong submissions -> lockout, correct ignored, then accepted again
        for (int i = 0; i < 3; i++) begin key(BAD_PW); quiet(1); end
        check("lockout_on", lockout, LOCK_EN);
        key(GOOD_PW);
        quiet(LOCKC);
        check("lockout_off", lockout, 1'b0);
        key(GOOD_PW);
        check("rearm", setup_on, 1'b1);
        quiet(4);

        // reset in SETUP with a commit strobe pending: no commit
        dsn = rand_cfg();
        rst = 1'b1; dok = 1'b1; tick(1'b1);
        rst = 1'b0; dok = 1'b0;
        quiet(2);
        check("rst_mid_setup_cfg", cfg, CFG_DEF);

        // randomized traffic
        for (int blk = 0; blk < 16; blk++) begin
            int density;
            density = $urandom_range(2, 80);
            for (int c = 0; c < 250; c++) begin
                int r;
                rst = ($urandom_range(0, 599) == 0);
                dok = ($urandom_range(0, 39) == 0);
                dsn = rand_cfg();
                bcd_op = $urandom; bcd_setup = $urandom; sde = 1'($urandom);
                dv = ($urandom_range(0, density - 1) == 0);
                r = $urandom_range(0, 2);
                if (r == 0)      dv_val = {m_cfg[75:0], 4'hB};
                else if (r == 1) dv_val = rand_keys(4'hB);
                else             dv_val = rand_keys(4'($urandom_range(0, 9)));
                tick(1'b1);
            end
        end
        rst = 1'b0; dv = 1'b0; dok = 1'b0;
        quiet(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/setup_ctrl.md
SETUP_CTRL -- requirements
Module: setup_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 10000: inactivity cycles in SETUP before abort.
REQ-002 Parameter MAX_FAIL, default 3: consecutive wrong master submissions before lockout.
REQ-003 Parameter LOCK_CYCLES, default 30000: lockout duration in cycles.
REQ-004 clk  in  1  single system clock; all logic on posedge clk.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 digitos_value  in  senhaPac_t  keypad buffer; digits[0] is the newest nibble; unused nibbles are 0xF.
REQ-007 digitos_valid  in  1  one-cycle strobe, digitos_value is valid.
REQ-008 bcd_op / bcd_setup  in  bcdPac_t  display data from the operational and setup blocks.
REQ-009 setup_display_en  in  1  display enable from the setup block.
REQ-010 data_setup_new  in  setupPac_t, and data_setup_ok  in  1: config and strobe from the setup block.
REQ-011 setup_on  out  1  setup-entry request to the setup block.
REQ-012 setup_abort  out  1  one-cycle reset pulse to the setup block.
REQ-013 setup_digitos_valid / op_digitos_valid  out  1  digitos_valid routed to the owning block.
REQ-014 bcd_out  out  bcdPac_t, and display_en  out  1: muxed display.
REQ-015 cfg  out  setupPac_t  active configuration.
REQ-016 in_setup  out  1  high in ARM or SETUP.
REQ-017 lockout  out  1  high in LOCKOUT.

Function
REQ-018 States: OPER, ARM, SETUP, COMMIT, LOCKOUT.
REQ-019 Master submission: digitos_valid in OPER with digits[0]==0xB; match iff {4'hF, digits[19:1]} == cfg.senha_master.digits.
REQ-020 OPER: match -> ARM, fail counter cleared; mismatch -> fail counter +1; other strobes -> op_digitos_valid.
REQ-021 Submission strobes are consumed: the strobe that ends a match or mismatch is never forwarded to either block.
REQ-022 ARM: setup_on=1 for exactly 2 cycles, then SETUP; strobes arriving in ARM are dropped.
REQ-023 SETUP: digitos_valid -> setup_digitos_valid, same cycle, combinational; op_digitos_valid=0.
REQ-024 SETUP: data_setup_ok=1 -> COMMIT; next cycle cfg<=data_setup_new, then OPER, exactly 1 cycle in COMMIT.
REQ-025 SETUP timeout: counter reloads on every digitos_valid; at TIMEOUT_CYCLES idle -> setup_abort pulse, then OPER with cfg unchanged.
REQ-026 Simultaneous data_setup_ok and timeout expiry: commit wins, no abort.
REQ-027 Display: in ARM/SETUP, bcd_out=bcd_setup and display_en=setup_display_en; otherwise bcd_out=bcd_op and display_en=1.
REQ-028 Fail counter saturates at MAX_FAIL; reaching MAX_FAIL -> LOCKOUT.
REQ-029 LOCKOUT: every strobe is dropped; after LOCK_CYCLES -> OPER with fail counter cleared.
REQ-030 data_setup_ok outside SETUP is ignored.

Reset
REQ-031 rst=1 at a clock edge -> state OPER, counters 0, setup_on=0, setup_abort=0, in_setup=0, lockout=0.
REQ-032 cfg reset value: bip_status=1, bip_time=5, tranca_aut_time=5; senha_master = 16×0xF then 1,2,3,4 (digits[0]=4); senha_1..4 all 0xF.
REQ-033 rst in any state, including mid-ARM or mid-SETUP, aborts with no commit; cfg returns to its reset value.

Configuration
REQ-034 Macro SETUP_CTRL_LOCKOUT_EN defined: fail counter and LOCKOUT state are compiled in per REQ-028/029.
REQ-035 Macro SETUP_CTRL_LOCKOUT_EN undefined: mismatches are consumed and ignored, LOCKOUT is unreachable, lockout is tied 0.

Verification
REQ-036 Default cfg; submit 1,2,3,4,# -> setup_on high 2 cycles, in_setup=1, bcd_out follows bcd_setup.
REQ-037 In SETUP, pulse data_setup_ok with bip_time=23 -> cfg.bip_time=23 two cycles later, in_setup=0, state OPER.
REQ-038 In SETUP, TIMEOUT_CYCLES=50 and no keys -> setup_abort pulse at cycle 50, cfg unchanged, in_setup=0.
REQ-039 LOCKOUT_EN, MAX_FAIL=3, LOCK_CYCLES=100: submit 9,9,9,9,# three times -> lockout=1; a correct password is ignored; lockout=0 after 100 cycles; the correct password then enters ARM.
REQ-040 In SETUP, assert rst -> state OPER, setup_on=0, cfg back to its reset value, no commit.
REQ-041 In OPER, strobe digit 5 -> op_digitos_valid=1 and setup_digitos_valid=0 in the same cycle.
